// File: rtl/rr_operand_sequencer_if.sv
// rtl/rr_operand_sequencer_if.sv - client, slave-bus and result signals of the operand sequencer
interface rr_operand_sequencer_if #(
  parameter int N    = 32,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   coe_req_valid;
  logic [NREQ*N-1:0] coe_req_a;
  logic [NREQ*N-1:0] coe_req_b;
  logic [NREQ-1:0]   coe_req_ready;
  logic [NREQ-1:0]   coe_rsp_valid;
  logic [N-1:0]      coe_rsp_data;
  logic              coe_busy;
  logic [7:0]        avm_m0_address;
  logic              avm_m0_write;
  logic [N-1:0]      avm_m0_writedata;
  logic [N-1:0]      coe_r_in;

  // master: requesters plus the arithmetic slave; slave: the sequencer itself
  modport master (
    output coe_req_valid, coe_req_a, coe_req_b, coe_r_in,
    input  coe_req_ready, coe_rsp_valid, coe_rsp_data, coe_busy,
    input  avm_m0_address, avm_m0_write, avm_m0_writedata
  );

  modport slave (
    input  coe_req_valid, coe_req_a, coe_req_b, coe_r_in,
    output coe_req_ready, coe_rsp_valid, coe_rsp_data, coe_busy,
    output avm_m0_address, avm_m0_write, avm_m0_writedata
  );
endinterface

// File: rtl/rr_operand_sequencer.sv
// rtl/rr_operand_sequencer.sv - round-robin sharing of one A*8-B Avalon-MM slave among NREQ requesters
module rr_operand_sequencer #(
  parameter int          N       = 32,
  parameter int          NREQ    = 4,
  parameter int          RES_LAT = 2,
  parameter logic [7:0]  ADDR_A  = 8'h00,
  parameter logic [7:0]  ADDR_B  = 8'h01
) (
  input  logic                  csi_clk,
  input  logic                  rsi_reset_n,
  rr_operand_sequencer_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(RES_LAT + 1);

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, WAIT_R, RESP} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   cur;
  logic [N-1:0]    op_b;
  logic [CW-1:0]   cnt;
  logic            write_q;
  logic [7:0]      address_q;
  logic [N-1:0]    writedata_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [N-1:0]    rsp_data_q;
  logic            busy_q;

  logic            gnt_any;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] ready_oh;

  // Scan from the farthest offset down so the nearest valid index at/after ptr wins.
  always_comb begin
    int j;
    j       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (bus.coe_req_valid[j[PW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = j[PW-1:0];
      end
    end
  end

  // Ready is gated by reset so an asserted reset silences the handshake at once.
  always_comb begin
    ready_oh = '0;
    if (state == IDLE && rsi_reset_n && gnt_any) begin
      ready_oh[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cur         <= '0;
      op_b        <= '0;
      cnt         <= '0;
      write_q     <= 1'b0;
      address_q   <= '0;
      writedata_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            cur         <= gnt_idx;
            op_b        <= bus.coe_req_b[int'(gnt_idx)*N +: N];
            ptr         <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
            write_q     <= 1'b1;
            address_q   <= ADDR_A;
            writedata_q <= bus.coe_req_a[int'(gnt_idx)*N +: N];
            busy_q      <= 1'b1;
            state       <= WR_A;
          end
        end
        WR_A: begin
          address_q   <= ADDR_B;
          writedata_q <= op_b;
          state       <= WR_B;
        end
        WR_B: begin
          write_q <= 1'b0;
          cnt     <= CW'(RES_LAT);
          state   <= WAIT_R;
        end
        WAIT_R: begin
          if (cnt == CW'(1)) begin
            rsp_data_q  <= bus.coe_r_in;
            rsp_valid_q <= NREQ'(1) << cur;
            state       <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.coe_req_ready    = ready_oh;
  assign bus.coe_rsp_valid    = rsp_valid_q;
  assign bus.coe_rsp_data     = rsp_data_q;
  assign bus.coe_busy         = busy_q;
  assign bus.avm_m0_address   = address_q;
  assign bus.avm_m0_write     = write_q;
  assign bus.avm_m0_writedata = writedata_q;
endmodule

// File: tb/tb_rr_operand_sequencer.sv
// tb/tb_rr_operand_sequencer.sv - randomized self-checking bench for rr_operand_sequencer
module tb_rr_operand_sequencer;
  localparam int         N       = 32;
  localparam int         NREQ    = 4;
  localparam int         RES_LAT = 2;
  localparam logic [7:0] ADDR_A  = 8'h00;
  localparam logic [7:0] ADDR_B  = 8'h01;
  localparam int         W       = 2*NREQ + 2 + 8 + N;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total     = 0;
  int bad       = 0;
  int cyc       = 0;
  int model_ptr = 0;

  logic [NREQ-1:0] vld = '0;
  logic [N-1:0]    op_a [NREQ];
  logic [N-1:0]    op_b [NREQ];
  logic [N-1:0]    sa = '0, sb = '0, sr = '0;

  rr_operand_sequencer_if #(.N(N), .NREQ(NREQ)) bus ();

  rr_operand_sequencer #(
    .N(N), .NREQ(NREQ), .RES_LAT(RES_LAT), .ADDR_A(ADDR_A), .ADDR_B(ADDR_B)
  ) dut (
    .csi_clk    (clk),
    .rsi_reset_n(rst_n),
    .bus        (bus.slave)
  );

  always_comb begin
    bus.coe_req_valid = vld;
    bus.coe_req_a     = '0;
    bus.coe_req_b     = '0;
    for (int k = 0; k < NREQ; k++) begin
      bus.coe_req_a[k*N +: N] = op_a[k];
      bus.coe_req_b[k*N +: N] = op_b[k];
    end
  end

  // Arithmetic slave: registered R = A*8 - B, valid RES_LAT (=2) cycles after the B write.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.avm_m0_write && bus.avm_m0_address == ADDR_A) sa <= bus.avm_m0_writedata;
    if (bus.avm_m0_write && bus.avm_m0_address == ADDR_B) sb <= bus.avm_m0_writedata;
    sr <= sa * 32'd8 - sb;
  end
  assign bus.coe_r_in = sr;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (ptr + k) % NREQ;
      if (v[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  // Waits for a grant, then follows the whole transaction cycle by cycle against the model.
  task automatic serve(input bit at_ready, input bit keep, input logic [NREQ-1:0] late_mask,
                       output int g_obs, output int t_obs, output logic [N-1:0] r_obs);
    int found, exp_g;
    logic [N-1:0] ea, eb, er;
    logic [W-1:0] got, want;
    found = at_ready;
    g_obs = -1;
    t_obs = cyc;
    r_obs = '0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      #1;
      if (|bus.coe_req_ready) found = 1;
      else @(negedge clk);
    end
    total++;
    if (found == 0) begin
      bad++;
      $display("FAIL ready_timeout got=%b want=nonzero", bus.coe_req_ready);
      return;
    end
    t_obs = cyc;
    for (int k = 0; k < NREQ; k++) if (bus.coe_req_ready[k]) g_obs = k;
    exp_g = rr_pick(vld, model_ptr);
    total++;
    if (exp_g < 0 || bus.coe_req_ready !== NREQ'(1) << exp_g) begin
      bad++;
      $display("FAIL grant got=%b want_idx=%0d", bus.coe_req_ready, exp_g);
      return;
    end
    ea = op_a[exp_g];
    eb = op_b[exp_g];
    er = ea * 32'd8 - eb;
    model_ptr = (exp_g + 1) % NREQ;
    for (int k = 1; k <= RES_LAT + 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (keep) begin
          op_a[exp_g] = $urandom;
          op_b[exp_g] = $urandom;
        end else begin
          vld[exp_g] = 1'b0;
        end
      end
      if (k == 3) vld = vld | late_mask;
      #1;
      got = {bus.coe_req_ready, bus.coe_rsp_valid, bus.coe_busy, bus.avm_m0_write,
             bus.avm_m0_address, bus.avm_m0_writedata};
      if (k <= RES_LAT + 2)
        want = {{NREQ{1'b0}}, {NREQ{1'b0}}, 1'b1, (k <= 2),
                (k == 1) ? ADDR_A : ADDR_B, (k == 1) ? ea : eb};
      else
        want = {{NREQ{1'b0}}, NREQ'(1) << exp_g, 1'b1, 1'b0, ADDR_B, eb};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL txn_cycle%0d got=%h want=%h", k, got, want);
      end
    end
    r_obs = bus.coe_rsp_data;
    total++;
    if (bus.coe_rsp_data !== er) begin
      bad++;
      $display("FAIL rsp_data got=%h want=%h", bus.coe_rsp_data, er);
    end
  endtask

  task automatic apply_reset(input logic [NREQ-1:0] v);
    @(negedge clk);
    rst_n = 1'b0;
    vld   = v;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vld   = '1;
    #1;
    total++;
    if ({bus.coe_req_ready, bus.coe_rsp_valid} !== '0) begin
      bad++;
      $display("FAIL reset_strobes got=%b want=0", {bus.coe_req_ready, bus.coe_rsp_valid});
    end
    total++;
    if ({bus.coe_busy, bus.avm_m0_write, bus.avm_m0_address, bus.avm_m0_writedata,
         bus.coe_rsp_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {bus.coe_busy, bus.avm_m0_write,
               bus.avm_m0_address, bus.avm_m0_writedata, bus.coe_rsp_data});
    end
    vld = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_single();
    int g, t;
    logic [N-1:0] r;
    @(negedge clk);
    op_a[0] = 32'd5;
    op_b[0] = 32'd3;
    vld     = 4'b0001;
    serve(0, 0, '0, g, t, r);
    total++;
    if (g !== 0 || r !== 32'd37) begin
      bad++;
      $display("FAIL single got=g%0d r%0d want=g0 r37", g, r);
    end
    @(negedge clk);
    #1;
    total++;
    if ({bus.coe_rsp_valid, bus.coe_req_ready, bus.coe_busy, bus.coe_rsp_data} !==
        {4'b0, 4'b0, 1'b0, 32'd37}) begin
      bad++;
      $display("FAIL rsp_hold got=%h want=%h",
               {bus.coe_rsp_valid, bus.coe_req_ready, bus.coe_busy, bus.coe_rsp_data},
               {4'b0, 4'b0, 1'b0, 32'd37});
    end
  endtask

  task automatic test_wrap();
    int g, t;
    logic [N-1:0] r;
    op_a[2] = 32'd0;
    op_b[2] = 32'd1;
    vld     = 4'b0100;
    serve(0, 0, '0, g, t, r);
    total++;
    if (r !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL wrap_under got=%h want=ffffffff", r);
    end
    op_a[3] = 32'h2000_0000;
    op_b[3] = 32'd0;
    vld     = 4'b1000;
    serve(0, 0, '0, g, t, r);
    total++;
    if (r !== 32'd0) begin
      bad++;
      $display("FAIL wrap_over got=%h want=0", r);
    end
  endtask

  task automatic test_round_robin();
    int g, t, t_prev;
    logic [N-1:0] r;
    int exp_order [6] = '{0, 1, 2, 3, 0, 1};
    for (int k = 0; k < NREQ; k++) begin
      op_a[k] = $urandom;
      op_b[k] = $urandom;
    end
    apply_reset('1);
    t_prev = 0;
    for (int i = 0; i < 6; i++) begin
      serve(0, 1, '0, g, t, r);
      total++;
      if (g !== exp_order[i]) begin
        bad++;
        $display("FAIL rr_order%0d got=%0d want=%0d", i, g, exp_order[i]);
      end
      if (i > 0) begin
        total++;
        if (t - t_prev !== 4 + RES_LAT) begin
          bad++;
          $display("FAIL rr_period%0d got=%0d want=%0d", i, t - t_prev, 4 + RES_LAT);
        end
      end
      t_prev = t;
    end
    vld = '0;
  endtask

  task automatic test_pointer();
    int g, t;
    logic [N-1:0] r;
    @(negedge clk);
    vld = 4'b0100;
    serve(0, 0, '0, g, t, r);
    vld = 4'b1010;
    serve(0, 0, '0, g, t, r);
    total++;
    if (g !== 3) begin
      bad++;
      $display("FAIL ptr_first got=%0d want=3", g);
    end
    serve(0, 0, '0, g, t, r);
    total++;
    if (g !== 1) begin
      bad++;
      $display("FAIL ptr_second got=%0d want=1", g);
    end
  endtask

  task automatic test_reset_midop();
    int g, t, found;
    logic [N-1:0] r;
    @(negedge clk);
    vld   = 4'b0010;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      #1;
      if (|bus.coe_req_ready) found = 1;
      else @(negedge clk);
    end
    total++;
    if (found == 0) begin
      bad++;
      $display("FAIL midop_ready got=0 want=nonzero");
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    vld   = 4'b1001;
    #1;
    total++;
    if ({bus.avm_m0_write, bus.coe_req_ready, bus.coe_rsp_valid, bus.coe_busy} !== '0) begin
      bad++;
      $display("FAIL midop_reset got=%b want=0",
               {bus.avm_m0_write, bus.coe_req_ready, bus.coe_rsp_valid, bus.coe_busy});
    end
    repeat (2) begin
      @(negedge clk);
      #1;
      total++;
      if (bus.coe_rsp_valid !== '0) begin
        bad++;
        $display("FAIL midop_norsp got=%b want=0", bus.coe_rsp_valid);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
    serve(0, 0, '0, g, t, r);
    total++;
    if (g !== 0) begin
      bad++;
      $display("FAIL midop_regrant got=%0d want=0", g);
    end
    vld = '0;
  endtask

  task automatic test_idle_late();
    int g, t;
    logic [N-1:0] r;
    vld = '0;
    repeat (6) begin
      @(negedge clk);
      #1;
      total++;
      if ({bus.avm_m0_write, bus.coe_busy, bus.coe_req_ready} !== '0) begin
        bad++;
        $display("FAIL idle_quiet got=%b want=0",
                 {bus.avm_m0_write, bus.coe_busy, bus.coe_req_ready});
      end
    end
    apply_reset('0);
    op_a[0] = $urandom;
    op_b[0] = $urandom;
    op_a[1] = $urandom;
    op_b[1] = $urandom;
    vld     = 4'b0001;
    serve(0, 0, 4'b0010, g, t, r);
    @(negedge clk);
    #1;
    total++;
    if (bus.coe_req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL late_ready got=%b want=0010", bus.coe_req_ready);
    end
    serve(1, 0, '0, g, t, r);
  endtask

  task automatic test_random();
    int g, t;
    logic [N-1:0] r;
    logic [NREQ-1:0] nv;
    for (int i = 0; i < 16; i++) begin
      nv = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int k = 0; k < NREQ; k++) begin
        if (!vld[k] && nv[k]) begin
          op_a[k] = $urandom;
          op_b[k] = $urandom;
        end
      end
      vld = vld | nv;
      serve(0, 1'($urandom_range(0, 1)), '0, g, t, r);
    end
    vld = '0;
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      op_a[k] = '0;
      op_b[k] = '0;
    end
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_pointer();
    test_reset_midop();
    test_idle_late();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
